// File: rtl/curve25519_job_ctrl_if.sv
// Job, core and response signal bundle for curve25519_job_ctrl.
// The master side is the host/core environment; the slave side is the controller.
interface curve25519_job_ctrl_if;
  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_scalar;
  logic [254:0] job_point;
  logic         core_start;
  logic [254:0] core_n;
  logic [254:0] core_q;
  logic         core_done;
  logic [254:0] core_out;
  logic         res_valid;
  logic         res_ready;
  logic [254:0] res_data;
  logic         res_err;
  logic         busy;

  modport master (
    output job_valid, job_scalar, job_point, core_done, core_out, res_ready,
    input  job_ready, core_start, core_n, core_q, res_valid, res_data, res_err, busy
  );

  modport slave (
    input  job_valid, job_scalar, job_point, core_done, core_out, res_ready,
    output job_ready, core_start, core_n, core_q, res_valid, res_data, res_err, busy
  );
endinterface

// File: rtl/curve25519_job_ctrl.sv
// X25519 job front end: clamps the scalar, runs the core start/done handshake
// with a timeout, and returns the result on a valid/ready response port.
module curve25519_job_ctrl #(
  parameter bit          CLAMP          = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 2097152,
  parameter int unsigned CNT_W          = 22
) (
  input logic                  clock,
  input logic                  reset,
  curve25519_job_ctrl_if.slave bus
);
  localparam int unsigned KEY_W = 255;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [KEY_W-1:0] n_q, n_nxt, q_q, q_nxt, data_q, data_nxt;
  logic             err_q, err_nxt;
  logic             ready_q, start_q, valid_q, busy_q;
  logic [KEY_W-1:0] clamped_c;
  logic             unused_scalar_msb;

  // Bit 255 of the scalar never reaches the core.
  assign unused_scalar_msb = bus.job_scalar[255];

  always_comb begin
    if (CLAMP) clamped_c = {1'b1, bus.job_scalar[253:3], 3'b000};
    else       clamped_c = bus.job_scalar[254:0];
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    n_nxt     = n_q;
    q_nxt     = q_q;
    data_nxt  = data_q;
    err_nxt   = err_q;
    unique case (state)
      IDLE: begin
        if (bus.job_valid && ready_q) begin
          n_nxt     = clamped_c;
          q_nxt     = bus.job_point;
          state_nxt = START;
        end
      end
      START: begin
        cnt_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A completion in the last count cycle still wins over the timeout.
        if (bus.core_done) begin
          data_nxt  = bus.core_out;
          err_nxt   = 1'b0;
          state_nxt = RESP;
        end else if (cnt == CNT_LAST) begin
          data_nxt  = '0;
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.res_ready) state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      n_q     <= '0;
      q_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      n_q     <= n_nxt;
      q_q     <= q_nxt;
      data_q  <= data_nxt;
      err_q   <= err_nxt;
      ready_q <= (state_nxt == IDLE);
      start_q <= (state_nxt == START);
      valid_q <= (state_nxt == RESP);
      busy_q  <= (state_nxt != IDLE);
    end
  end

  assign bus.job_ready  = ready_q;
  assign bus.core_start = start_q;
  assign bus.core_n     = n_q;
  assign bus.core_q     = q_q;
  assign bus.res_valid  = valid_q;
  assign bus.res_data   = data_q;
  assign bus.res_err    = err_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_curve25519_job_ctrl.sv
// Directed bench for curve25519_job_ctrl with a stub core driven from the stimulus.
// DUT a: clamping on, 8-cycle timeout; DUT b: clamping off.
module tb_curve25519_job_ctrl;
  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   starts_a;
  int   s0;

  curve25519_job_ctrl_if bus_a ();
  curve25519_job_ctrl_if bus_b ();

  curve25519_job_ctrl #(.CLAMP(1'b1), .TIMEOUT_CYCLES(8), .CNT_W(4)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a)
  );
  curve25519_job_ctrl #(.CLAMP(1'b0), .TIMEOUT_CYCLES(8), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (bus_a.core_start) starts_a++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk255(input string tag, input logic [254:0] obs, input logic [254:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [255:0] known;
  logic [255:0] scal3;
  logic [254:0] e_n;
  logic [254:0] ones255;
  logic [254:0] zero255;

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    starts_a = 0;
    known    = 256'h743bcb585f9990edc2cfc4af84f6ff300729bb5facda28154362cd47a37de52f;
    scal3    = 256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;
    ones255  = '1;
    zero255  = '0;

    reset = 1'b1;
    bus_a.job_valid = 1'b0; bus_a.job_scalar = '0; bus_a.job_point = '0;
    bus_a.core_done = 1'b0; bus_a.core_out = '0;   bus_a.res_ready = 1'b1;
    bus_b.job_valid = 1'b0; bus_b.job_scalar = '0; bus_b.job_point = '0;
    bus_b.core_done = 1'b0; bus_b.core_out = '0;   bus_b.res_ready = 1'b1;
    tick(); tick();

    // Reset values
    chk1("rst_job_ready", bus_a.job_ready, 1'b1);
    chk1("rst_busy", bus_a.busy, 1'b0);
    chk1("rst_res_valid", bus_a.res_valid, 1'b0);
    chk1("rst_core_start", bus_a.core_start, 1'b0);
    chk255("rst_core_n", bus_a.core_n, zero255);
    reset = 1'b0;
    tick();

    // Known vector: scalar 2^254 is unchanged by clamping
    s0 = starts_a;
    e_n = '0; e_n[254] = 1'b1;
    bus_a.job_scalar = '0; bus_a.job_scalar[254] = 1'b1;
    bus_a.job_point = 255'd9;
    bus_a.job_valid = 1'b1;
    tick();
    bus_a.job_valid = 1'b0;
    chk1("kv_core_start", bus_a.core_start, 1'b1);
    chk1("kv_job_ready_low", bus_a.job_ready, 1'b0);
    chk1("kv_busy", bus_a.busy, 1'b1);
    chk255("kv_core_n", bus_a.core_n, e_n);
    chk255("kv_core_q", bus_a.core_q, 255'd9);
    tick();
    chk1("kv_start_one_cycle", bus_a.core_start, 1'b0);
    bus_a.core_done = 1'b1; bus_a.core_out = known[254:0];
    tick();
    bus_a.core_done = 1'b0; bus_a.core_out = '0;
    chk1("kv_res_valid", bus_a.res_valid, 1'b1);
    chk255("kv_res_data", bus_a.res_data, known[254:0]);
    chk1("kv_res_err", bus_a.res_err, 1'b0);
    tick();
    chk1("kv_back_idle_ready", bus_a.job_ready, 1'b1);
    chk1("kv_res_valid_drop", bus_a.res_valid, 1'b0);
    chk_int("kv_start_pulses", starts_a - s0, 1);

    // Clamping of an all-ones scalar, with and without CLAMP
    e_n = '1; e_n[2:0] = 3'b000;
    bus_a.job_scalar = '1; bus_a.job_point = 255'd1; bus_a.job_valid = 1'b1;
    bus_b.job_scalar = '1; bus_b.job_point = 255'd1; bus_b.job_valid = 1'b1;
    tick();
    bus_a.job_valid = 1'b0; bus_b.job_valid = 1'b0;
    chk255("clamp_on_core_n", bus_a.core_n, e_n);
    chk255("clamp_off_core_n", bus_b.core_n, ones255);
    tick();
    bus_a.core_done = 1'b1; bus_a.core_out = 255'd77;
    tick();
    bus_a.core_done = 1'b0;
    chk255("clamp_res_data", bus_a.res_data, 255'd77);
    tick();

    // Backpressure and operand stability, with a second job already waiting
    bus_a.res_ready = 1'b0;
    bus_a.job_scalar = scal3; bus_a.job_point = 255'h5555; bus_a.job_valid = 1'b1;
    tick();
    bus_a.job_scalar = '1; bus_a.job_point = 255'd7;
    e_n = 255'h4123456789abcdef0123456789abcdef0123456789abcdef0123456789abcde8;
    chk255("bp_core_n", bus_a.core_n, e_n);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("bp_wait_job_ready", bus_a.job_ready, 1'b0);
      chk255("bp_wait_core_n", bus_a.core_n, e_n);
      chk255("bp_wait_core_q", bus_a.core_q, 255'h5555);
    end
    bus_a.core_done = 1'b1; bus_a.core_out = 255'h1234;
    tick();
    bus_a.core_done = 1'b0; bus_a.core_out = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus_a.core_done = 1'b1; bus_a.core_out = 255'hdead;
      end else begin
        bus_a.core_done = 1'b0;
      end
      chk1("bp_res_valid", bus_a.res_valid, 1'b1);
      chk255("bp_res_data", bus_a.res_data, 255'h1234);
      chk1("bp_job_ready", bus_a.job_ready, 1'b0);
      tick();
    end
    bus_a.core_done = 1'b0;
    chk1("bp_res_valid_held", bus_a.res_valid, 1'b1);
    bus_a.res_ready = 1'b1;
    tick();
    chk1("bp_idle_after_resp", bus_a.busy, 1'b0);
    chk1("bp_job_ready_back", bus_a.job_ready, 1'b1);

    // Second job accepted now; it runs into the timeout
    s0 = starts_a;
    tick();
    bus_a.job_valid = 1'b0;
    e_n = '1; e_n[2:0] = 3'b000;
    chk1("j2_core_start", bus_a.core_start, 1'b1);
    chk255("j2_core_n", bus_a.core_n, e_n);
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk1("to_no_valid_early", bus_a.res_valid, 1'b0);
    end
    tick();
    chk1("to_res_valid", bus_a.res_valid, 1'b1);
    chk1("to_res_err", bus_a.res_err, 1'b1);
    chk255("to_res_data", bus_a.res_data, zero255);
    tick();
    chk1("to_idle", bus_a.job_ready, 1'b1);

    // Completion on the final count cycle beats the timeout
    bus_a.job_scalar = '0; bus_a.job_point = 255'd3; bus_a.job_valid = 1'b1;
    tick();
    bus_a.job_valid = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk1("late_still_waiting", bus_a.res_valid, 1'b0);
    bus_a.core_done = 1'b1; bus_a.core_out = 255'habc;
    tick();
    bus_a.core_done = 1'b0;
    chk1("late_res_valid", bus_a.res_valid, 1'b1);
    chk1("late_res_err", bus_a.res_err, 1'b0);
    chk255("late_res_data", bus_a.res_data, 255'habc);
    tick();

    // Spurious core_done while idle
    bus_a.core_done = 1'b1; bus_a.core_out = 255'h99;
    tick(); tick();
    bus_a.core_done = 1'b0;
    chk1("spur_idle_busy", bus_a.busy, 1'b0);
    chk1("spur_idle_valid", bus_a.res_valid, 1'b0);
    chk1("spur_idle_ready", bus_a.job_ready, 1'b1);

    // Reset in the middle of WAIT
    bus_a.job_scalar = '1; bus_a.job_point = 255'd5; bus_a.job_valid = 1'b1;
    tick();
    bus_a.job_valid = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk1("mrst_job_ready", bus_a.job_ready, 1'b1);
    chk1("mrst_busy", bus_a.busy, 1'b0);
    chk1("mrst_res_valid", bus_a.res_valid, 1'b0);
    chk255("mrst_core_n", bus_a.core_n, zero255);
    chk255("mrst_core_q", bus_a.core_q, zero255);
    tick();
    reset = 1'b0;
    s0 = starts_a;
    bus_a.core_done = 1'b1; bus_a.core_out = 255'h77;
    tick();
    bus_a.core_done = 1'b0;
    tick();
    chk1("mrst_stale_done_valid", bus_a.res_valid, 1'b0);
    chk1("mrst_stale_done_busy", bus_a.busy, 1'b0);
    chk_int("mrst_no_restart", starts_a - s0, 0);

    // Fresh job after reset completes normally
    bus_a.job_scalar = '0; bus_a.job_point = 255'd11; bus_a.job_valid = 1'b1;
    tick();
    bus_a.job_valid = 1'b0;
    chk1("post_core_start", bus_a.core_start, 1'b1);
    tick();
    bus_a.core_done = 1'b1; bus_a.core_out = 255'h4242;
    tick();
    bus_a.core_done = 1'b0;
    chk1("post_res_valid", bus_a.res_valid, 1'b1);
    chk255("post_res_data", bus_a.res_data, 255'h4242);
    tick();
    chk1("post_idle", bus_a.job_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/curve25519_job_ctrl.md
Name: curve25519_job_ctrl

Overview:
- Initiator-side front end for the `curve25519` scalar-multiplication core.
- Accepts X25519 jobs (raw scalar + u-coordinate) on a valid/ready request port.
- Applies RFC 7748 scalar clamping, then drives the core's start/done handshake, holding operands stable for the whole operation.
- Returns the result, or a timeout error, on a valid/ready response port; one job is in flight at a time.

Parameters:
- CLAMP, 1, 1 = apply X25519 clamping to the scalar; 0 = pass scalar bits [254:0] unchanged.
- TIMEOUT_CYCLES, 2097152, WAIT cycles without core_done before the job is aborted (≥ 2).
- CNT_W, 22, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- job_valid  in  1  request valid.
- job_ready  out  1  request ready; asserted only in IDLE.
- job_scalar  in  256  raw little-endian 32-byte scalar.
- job_point  in  255  u-coordinate, with bit 255 already dropped by the caller.
- core_start  out  1  one-cycle start pulse to the core.
- core_n  out  255  clamped scalar to the core.
- core_q  out  255  point to the core.
- core_done  in  1  core completion strobe.
- core_out  in  255  core result, valid while core_done = 1.
- res_valid  out  1  response valid.
- res_ready  in  1  response ready.
- res_data  out  255  result; zero on error.
- res_err  out  1  1 = job aborted by timeout.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async assert, sync deassert on clock):
  - State = IDLE.
  - job_ready = 1; core_start, res_valid, res_err, busy = 0.
  - core_n, core_q, res_data = 0; counter = 0.
  - Reset mid-job abandons the job; the controller issues no further core_start until a new request.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - Handshake when job_valid & job_ready.
  - Latch core_n = clamp(job_scalar) and core_q = job_point; go to START.
  - Clamp (CLAMP = 1): take job_scalar[254:0], force bit 254 = 1 and bits [2:0] = 0; bit 255 is discarded.
- START:
  - core_start = 1 for exactly this one cycle; counter cleared; go to WAIT.
  - core_n and core_q stay constant from the handshake until the controller leaves WAIT.
- WAIT:
  - Counter increments each cycle.
  - If core_done = 1: res_data = core_out, res_err = 0, go to RESP. core_done takes priority over timeout in the same cycle.
  - Else if counter reaches TIMEOUT_CYCLES-1: res_data = 0, res_err = 1, go to RESP.
  - A core_done seen in any other state is ignored.
- RESP:
  - res_valid = 1; res_data and res_err held stable until res_valid & res_ready.
  - On that handshake, go to IDLE; job_ready reasserts the next cycle. No same-cycle job acceptance.
- Latency: handshake at cycle t → core_start at t+1 → WAIT from t+2. core_done at cycle d → res_valid = 1 from d+1.
- Throughput: at most one job per (core latency + 3) cycles.
- Ready/valid: job_ready does not depend combinationally on job_valid. res_valid does not drop without res_ready.
- busy = (state ≠ IDLE).

Test Plan:
- Known vector, real core:
  - Stimulus: job_scalar = 0x4000…00, job_point = 9, res_ready = 1.
  - Required: core_n = 0x4000…00 (clamp is identity); exactly one core_start pulse; res_data = 0x743bcb585f9990edc2cfc4af84f6ff300729bb5facda28154362cd47a37de52f; res_err = 0.
- Clamping, stub core:
  - Stimulus: job_scalar = all ones.
  - Required: core_n = 0x7fff…fff8; with CLAMP = 0, core_n = 0x7fff…ffff.
- Backpressure and operand stability, stub core with done after 5 cycles returning 0x1234:
  - Stimulus: res_ready = 0 for 10 cycles; job_valid held high with a second job.
  - Required: res_data = 0x1234 held stable; job_ready = 0 throughout; core_n and core_q unchanged from handshake through WAIT.
  - Second job accepted only after the response handshake.
- Timeout, TIMEOUT_CYCLES = 8, core_done never asserted:
  - Required: res_valid rises 8 cycles after WAIT entry, with res_err = 1 and res_data = 0.
  - Variant: core_done on the final count cycle → res_err = 0, result delivered.
- Reset mid-WAIT:
  - Stimulus: assert reset asynchronously, then release, then issue a new job.
  - Required: all outputs 0 and job_ready = 1 immediately on assertion; a stale core_done after release gives no res_valid; the new job completes normally.
- Spurious core_done pulses:
  - Stimulus: core_done pulses while in IDLE and in RESP.
  - Required: no state change, no extra res_valid.
